// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - SID register map constants and write-event type
package sid_pkg;

    localparam int NUM_SID_REGS = 25;

    localparam logic [4:0] FREQ_LO_V1   = 5'h00;
    localparam logic [4:0] CTRL_V1      = 5'h04;
    localparam logic [4:0] AD_V1        = 5'h05;
    localparam logic [4:0] SR_V1        = 5'h06;
    localparam logic [4:0] VOICE_STRIDE = 5'h07;
    localparam logic [4:0] MODE_VOL     = 5'h18;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } sid_write_t;

    // Control register address of voice 0..2
    function automatic logic [4:0] ctrl_addr(input logic [1:0] voice);
        return CTRL_V1 + VOICE_STRIDE * {3'b000, voice};
    endfunction

endpackage

// File: rtl/sid_write_monitor_if.sv
// rtl/sid_write_monitor_if.sv - SID write bus plus event-log stream
interface sid_write_monitor_if;

    logic [4:0]  bus_addr;
    logic [7:0]  bus_data;
    logic        bus_n_cs;
    logic        bus_rw;
    logic [12:0] log_tdata;
    logic        log_tvalid;
    logic        log_tready;

    modport master (
        output bus_addr, bus_data, bus_n_cs, bus_rw, log_tready,
        input  log_tdata, log_tvalid
    );

    modport slave (
        input  bus_addr, bus_data, bus_n_cs, bus_rw, log_tready,
        output log_tdata, log_tvalid
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
    parameter  int WIDTH = 13,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_1k,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_1k) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_1k) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sid_write_monitor.sv
// rtl/sid_write_monitor.sv - SID write shadow and event log; SID_WRITE_MONITOR_GATE_COUNT_EN adds gate_count
module sid_write_monitor
    import sid_pkg::*;
#(
    parameter  int LOG_DEPTH = 8,
    parameter  int NUM_REGS  = NUM_SID_REGS,
    localparam int CW        = $clog2(LOG_DEPTH + 1)
) (
    input  logic                  clk_1k,
    input  logic                  n_reset,
    sid_write_monitor_if.slave    bus,
    input  logic [4:0]            rd_addr,
    output logic [7:0]            rd_data,
    output logic [CW-1:0]         log_count,
    output logic                  overflow,
    output logic                  bad_addr,
    input  logic                  clr_flags
`ifdef SID_WRITE_MONITOR_GATE_COUNT_EN
    ,
    output logic [23:0]           gate_count
`endif
);

    logic [7:0] shadow [NUM_REGS];
    sid_write_t ev;
    logic       wr;
    logic       legal;
    logic       pop;
    logic       full;
    logic       empty;

    assign wr    = ~bus.bus_n_cs & ~bus.bus_rw;
    assign legal = int'(bus.bus_addr) < NUM_REGS;
    assign ev    = '{addr: bus.bus_addr, data: bus.bus_data};
    assign pop   = ~empty & bus.log_tready;

    assign bus.log_tvalid = ~empty;

    sync_fifo #(
        .WIDTH ($bits(sid_write_t)),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk_1k    (clk_1k),
        .n_reset   (n_reset),
        .push      (wr),
        .push_data (ev),
        .pop       (bus.log_tready),
        .head      (bus.log_tdata),
        .count     (log_count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk_1k) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 8'h00;
        end else if (wr && legal) begin
            shadow[bus.bus_addr] <= bus.bus_data;
        end
    end

    // Registered read sees the pre-write value on a same-cycle collision
    always_ff @(posedge clk_1k) begin
        if (!n_reset) begin
            rd_data <= 8'h00;
        end else if (int'(rd_addr) < NUM_REGS) begin
            rd_data <= shadow[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end

    // Set beats clear so a flag raised in the clearing cycle is not lost
    always_ff @(posedge clk_1k) begin
        if (!n_reset) begin
            overflow <= 1'b0;
            bad_addr <= 1'b0;
        end else begin
            if (wr && full && !pop) overflow <= 1'b1;
            else if (clr_flags)     overflow <= 1'b0;
            if (wr && !legal)       bad_addr <= 1'b1;
            else if (clr_flags)     bad_addr <= 1'b0;
        end
    end

`ifdef SID_WRITE_MONITOR_GATE_COUNT_EN
    for (genvar v = 0; v < 3; v++) begin : g_gate
        localparam logic [4:0] CA = ctrl_addr(2'(v));
        logic [7:0] cnt;

        always_ff @(posedge clk_1k) begin
            if (!n_reset) begin
                cnt <= 8'h00;
            end else if (wr && bus.bus_addr == CA && bus.bus_data[0] && !shadow[CA][0]) begin
                cnt <= cnt + 8'd1;
            end
        end

        assign gate_count[8*v +: 8] = cnt;
    end
`endif

endmodule

// File: tb/tb_sid_write_monitor.sv
// tb/tb_sid_write_monitor.sv - scoreboard bench for sid_write_monitor
module tb_sid_write_monitor;
    import sid_pkg::*;

    localparam int LOG_DEPTH = 8;
    localparam int NREG      = 25;

    logic       clk_1k = 1'b0;
    logic       n_reset = 1'b0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [3:0] log_count;
    logic       overflow;
    logic       bad_addr;
    logic       clr_flags = 1'b0;
`ifdef SID_WRITE_MONITOR_GATE_COUNT_EN
    logic [23:0] gate_count;
`endif

    sid_write_monitor_if bus ();

    always #5 clk_1k = ~clk_1k;

    sid_write_monitor #(.LOG_DEPTH(LOG_DEPTH), .NUM_REGS(NREG)) dut (
        .clk_1k    (clk_1k),
        .n_reset   (n_reset),
        .bus       (bus.slave),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .log_count (log_count),
        .overflow  (overflow),
        .bad_addr  (bad_addr),
        .clr_flags (clr_flags)
`ifdef SID_WRITE_MONITOR_GATE_COUNT_EN
        ,
        .gate_count(gate_count)
`endif
    );

    // Reference model: state after the most recent modelled edge
    logic [7:0]  m_shadow [NREG];
    int          m_count, m_rd, m_gate [3];
    bit          m_ovf, m_bad;
    // Expectations for the DUT outputs currently visible
    int          e_count, e_rd, e_gate [3];
    bit          e_ovf, e_bad;
    logic [12:0] exp_q [$];
    bit          chk_en = 1'b0;

    int total = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_shadow[i] = 8'h00;
        m_count = 0; m_rd = 0; m_ovf = 0; m_bad = 0;
        for (int v = 0; v < 3; v++) m_gate[v] = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit rst, input bit wr, input logic [4:0] a, input logic [7:0] d,
                        input logic [4:0] ra, input bit rdy, input bit clr);
        bit pop, push, full_now;
        @(posedge clk_1k);
        #1;
        e_count = m_count; e_rd = m_rd; e_ovf = m_ovf; e_bad = m_bad;
        for (int v = 0; v < 3; v++) e_gate[v] = m_gate[v];
        chk_en = 1'b1;

        n_reset = ~rst;
        bus.bus_addr = a;
        bus.bus_data = d;
        rd_addr = ra;
        clr_flags = clr;
        bus.log_tready = rst ? 1'b0 : rdy;
        if (wr) begin
            bus.bus_n_cs = 1'b0; bus.bus_rw = 1'b0;
        end else if ($urandom_range(0, 1) != 0) begin
            bus.bus_n_cs = 1'b1; bus.bus_rw = 1'($urandom_range(0, 1));
        end else begin
            bus.bus_n_cs = 1'b0; bus.bus_rw = 1'b1;
        end

        if (rst) begin
            model_reset();
        end else begin
            m_rd = (int'(ra) < NREG) ? int'(m_shadow[ra]) : 0;
            pop = (m_count > 0) && rdy;
            push = 1'b0;
            full_now = (m_count == LOG_DEPTH);
            if (wr && int'(a) < NREG) begin
                for (int v = 0; v < 3; v++)
                    if (int'(a) == int'(CTRL_V1) + int'(VOICE_STRIDE) * v && d[0] && !m_shadow[a][0])
                        m_gate[v] = (m_gate[v] + 1) % 256;
                m_shadow[a] = d;
            end
            if (wr && int'(a) >= NREG) m_bad = 1'b1;
            else if (clr)              m_bad = 1'b0;
            if (wr && full_now && !pop) m_ovf = 1'b1;
            else begin
                if (clr) m_ovf = 1'b0;
                if (wr) begin
                    push = 1'b1;
                    exp_q.push_back({a, d});
                end
            end
            m_count = m_count - int'(pop) + int'(push);
        end
    endtask

    task automatic wr_step(input logic [4:0] a, input logic [7:0] d, input bit rdy);
        step(1'b0, 1'b1, a, d, 5'($urandom_range(0, 31)), rdy, 1'b0);
    endtask

    task automatic rd_step(input logic [4:0] ra, input bit rdy);
        step(1'b0, 1'b0, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), ra, rdy, 1'b0);
    endtask

    // Monitor: registered outputs against the model, log pops against the scoreboard
    always @(negedge clk_1k) begin
        if (chk_en) begin
            chk("log_count", 32'(log_count), 32'(e_count));
            chk("log_tvalid", 32'(bus.log_tvalid), 32'(e_count != 0));
            chk("overflow", 32'(overflow), 32'(e_ovf));
            chk("bad_addr", 32'(bad_addr), 32'(e_bad));
            chk("rd_data", 32'(rd_data), 32'(e_rd));
`ifdef SID_WRITE_MONITOR_GATE_COUNT_EN
            for (int v = 0; v < 3; v++)
                chk("gate_count", 32'(gate_count[8*v +: 8]), 32'(e_gate[v]));
`endif
            if (bus.log_tvalid === 1'b1 && bus.log_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("log_pop_unexpected", 32'(bus.log_tdata), 32'h1fff_ffff);
                end else begin
                    chk("log_tdata", 32'(bus.log_tdata), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    localparam int NPROG = 6;
    logic [4:0] prog_a [NPROG];
    logic [7:0] prog_d [NPROG];

    initial begin
        bus.bus_addr = '0; bus.bus_data = '0; bus.bus_n_cs = 1'b1;
        bus.bus_rw = 1'b1; bus.log_tready = 1'b0;
        model_reset();
        prog_a = '{MODE_VOL, AD_V1, SR_V1, 5'h01, FREQ_LO_V1, CTRL_V1};
        prog_d = '{8'd8, 8'd190, 8'd248, 8'd17, 8'd37, 8'd17};

        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);

        // Register programming with back-to-back writes, then read back
        for (int i = 0; i < NPROG; i++) wr_step(prog_a[i], prog_d[i], 1'b1);
        for (int i = 0; i < NPROG; i++) rd_step(prog_a[i], 1'b1);

        // Reset mid-operation with three events queued
        for (int i = 0; i < 3; i++) wr_step(MODE_VOL, 8'(i + 1), 1'b0);
        step(1'b1, 1'b0, '0, '0, MODE_VOL, 1'b0, 1'b0);
        rd_step(MODE_VOL, 1'b0);
        rd_step(MODE_VOL, 1'b0);

        // Overflow: ten writes with the consumer stalled
        for (int i = 0; i < 10; i++) wr_step(5'(i + 8), 8'(i * 3 + 1), 1'b0);
        for (int i = 0; i < 10; i++) rd_step(5'(i + 8), 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        // Push and pop at full
        wr_step(5'h13, 8'd33, 1'b1);
        rd_step(5'h13, 1'b0);
        for (int i = 0; i < 12; i++) rd_step(5'h13, 1'b1);

        // Bad address, read collision, clear-vs-set
        wr_step(5'h1B, 8'h55, 1'b1);
        rd_step(5'h1B, 1'b1);
        step(1'b0, 1'b1, AD_V1, 8'hAA, AD_V1, 1'b1, 1'b0);
        rd_step(AD_V1, 1'b1);
        rd_step(AD_V1, 1'b1);
        step(1'b0, 1'b1, 5'h1C, 8'h12, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
        rd_step('0, 1'b1);

        // Gate edges on voice 1 and voice 2 control registers
        step(1'b0, 1'b1, CTRL_V1, 8'd16, '0, 1'b1, 1'b0);
        wr_step(CTRL_V1, 8'd17, 1'b1);
        wr_step(CTRL_V1, 8'd17, 1'b1);
        wr_step(CTRL_V1, 8'd16, 1'b1);
        wr_step(CTRL_V1, 8'd17, 1'b1);
        wr_step(5'h0B, 8'd33, 1'b1);
        wr_step(5'h0B, 8'd33, 1'b1);
        rd_step(CTRL_V1, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, a,
                 8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        for (int i = 0; i < LOG_DEPTH + 4; i++) rd_step(5'($urandom_range(0, 31)), 1'b1);
        rd_step('0, 1'b0);
        @(posedge clk_1k);
        #1;
        chk("log_drained", 32'(exp_q.size()), 32'd0);
        chk("count_drained", 32'(log_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end

endmodule
